// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, the one-entry fetch buffer and the IF/ID register.
// Fetches through a req/ready handshake on memory shared with the data side.
module if_fetch_stage #(
    parameter int unsigned         ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PCWrite,
    input  logic              IFIDWrite,
    input  logic              flush,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              mem_busy,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       IFID_instr,
    output logic [ADDR_W-1:0] IFID_pc4,
    output logic              IFID_valid,
    output logic [4:0]        IFID_rs,
    output logic [4:0]        IFID_rt
);

    typedef enum logic [1:0] {StIdle, StReq, StFull, StDiscard} state_e;

    state_e            r_state, w_state_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic [ADDR_W-1:0] r_req_addr, w_req_addr_next;
    logic [31:0]       r_buf, w_buf_next;
    logic [31:0]       r_ifid_instr, w_ifid_instr_next;
    logic [ADDR_W-1:0] r_ifid_pc4, w_ifid_pc4_next;
    logic              r_ifid_valid, w_ifid_valid_next;

    logic              w_accept;
    logic              w_resp;
    logic              w_have;
    logic              w_take;
    logic [31:0]       w_word;
    logic [ADDR_W-1:0] w_pc_plus4;

    // Request outputs; a new fetch from IDLE is held off by reset, mem_busy and flush.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = r_pc;
        unique case (r_state)
            StIdle: begin
                imem_req  = rst_n && !mem_busy && !flush;
                imem_addr = r_pc;
            end
            StReq, StDiscard: begin
                imem_req  = 1'b1;
                imem_addr = r_req_addr;
            end
            StFull: begin
                imem_req  = 1'b0;
                imem_addr = r_pc;
            end
            default: begin
                imem_req  = 1'b0;
                imem_addr = r_pc;
            end
        endcase
    end

    assign w_accept   = PCWrite && IFIDWrite && !flush;
    assign w_resp     = imem_req && imem_ready;
    assign w_have     = (r_state == StFull) ||
                        (((r_state == StIdle) || (r_state == StReq)) && w_resp);
    assign w_word     = (r_state == StFull) ? r_buf : imem_rdata;
    assign w_take     = w_accept && w_have;
    assign w_pc_plus4 = r_pc + ADDR_W'(4);

    always_comb begin
        w_state_next    = r_state;
        w_req_addr_next = r_req_addr;
        w_buf_next      = r_buf;
        w_pc_next       = r_pc;

        if (flush) begin
            w_pc_next = branch_target;
        end else if (w_take) begin
            w_pc_next = w_pc_plus4;
        end

        unique case (r_state)
            StIdle, StReq: begin
                if (w_resp) begin
                    if (!flush && !w_accept) begin
                        w_state_next = StFull;
                        w_buf_next   = imem_rdata;
                    end else begin
                        w_state_next = StIdle;
                    end
                end else if ((r_state == StIdle) && imem_req) begin
                    w_state_next    = StReq;
                    w_req_addr_next = r_pc;
                end else if ((r_state == StReq) && flush) begin
                    // Outstanding request cannot be withdrawn; drop its response later.
                    w_state_next = StDiscard;
                end
            end
            StFull: begin
                if (flush || w_accept) begin
                    w_state_next = StIdle;
                end
            end
            StDiscard: begin
                if (w_resp) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_ifid_instr_next = r_ifid_instr;
        w_ifid_pc4_next   = r_ifid_pc4;
        w_ifid_valid_next = r_ifid_valid;
        if (flush || (IFIDWrite && !w_take)) begin
            w_ifid_instr_next = '0;
            w_ifid_pc4_next   = '0;
            w_ifid_valid_next = 1'b0;
        end else if (IFIDWrite) begin
            w_ifid_instr_next = w_word;
            w_ifid_pc4_next   = w_pc_plus4;
            w_ifid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= StIdle;
            r_pc         <= RESET_PC;
            r_req_addr   <= RESET_PC;
            r_buf        <= '0;
            r_ifid_instr <= '0;
            r_ifid_pc4   <= '0;
            r_ifid_valid <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_req_addr   <= w_req_addr_next;
            r_buf        <= w_buf_next;
            r_ifid_instr <= w_ifid_instr_next;
            r_ifid_pc4   <= w_ifid_pc4_next;
            r_ifid_valid <= w_ifid_valid_next;
        end
    end

    assign pc         = r_pc;
    assign IFID_instr = r_ifid_instr;
    assign IFID_pc4   = r_ifid_pc4;
    assign IFID_valid = r_ifid_valid;
    assign IFID_rs    = r_ifid_instr[25:21];
    assign IFID_rt    = r_ifid_instr[20:16];

endmodule
